// File: rtl/npu_quant_pkg.sv
// Shared quantisation constants and the vector-fill state type used by the
// requantisation packer and the vector-multiply units.
//   Q  : output quant width
//   DQ : signed accumulator width
//   MW : unsigned requant multiplier width
//   SW : right-shift amount width
package npu_quant_pkg;
    localparam int Q  = 8;
    localparam int DQ = 18;
    localparam int MW = 16;
    localparam int SW = 5;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_e;
endpackage

// File: rtl/requant_pipe.sv
// Three-stage requantisation datapath: multiply by M0, rounding arithmetic
// right shift, then zero-point add with optional ReLU clamp and saturation.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (valids only)
//   flush_i           : synchronous invalidate of every stage
//   vld_i, acc_i      : accepted accumulator element (signed, DQ bits)
//   m0_i, shift_i     : unsigned multiplier, right-shift amount
//   z_i, relu_i       : signed output zero point, ReLU clamp enable
//   vld_o, y_o        : stage-3 valid and saturated Q-bit result
module requant_pipe #(
    parameter int Q  = npu_quant_pkg::Q,
    parameter int DQ = npu_quant_pkg::DQ,
    parameter int MW = npu_quant_pkg::MW,
    parameter int SW = npu_quant_pkg::SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          vld_i,
    input  logic [DQ-1:0] acc_i,
    input  logic [MW-1:0] m0_i,
    input  logic [SW-1:0] shift_i,
    input  logic [Q-1:0]  z_i,
    input  logic          relu_i,
    output logic          vld_o,
    output logic [Q-1:0]  y_o
);
    localparam int PW = DQ + MW + 1;  // lossless signed product width
    localparam int YW = PW + 1;       // room for the zero-point add
    localparam logic signed [YW-1:0] Y_MAX = YW'((1 << (Q-1)) - 1);
    localparam logic signed [YW-1:0] Y_MIN = ~Y_MAX;

    // Round half up, then arithmetic shift; shift of zero passes through.
    function automatic logic signed [PW-1:0] round_shift(
        input logic signed [PW-1:0] p,
        input logic [SW-1:0]        sh
    );
        logic signed [PW-1:0] bias;
        if (sh == '0) return p;
        bias = PW'(1) << (sh - SW'(1));
        return (p + bias) >>> sh;
    endfunction

    function automatic logic signed [Q-1:0] sat_q(input logic signed [YW-1:0] y);
        if (y > Y_MAX) return Y_MAX[Q-1:0];
        if (y < Y_MIN) return Y_MIN[Q-1:0];
        return y[Q-1:0];
    endfunction

    logic signed [DQ-1:0] acc_s;
    logic signed [MW:0]   m0_s;
    logic signed [PW-1:0] p_p1_d, p_p1_q;
    logic signed [PW-1:0] r_p2_d, r_p2_q;
    logic signed [Q-1:0]  y_p3_d, y_p3_q;
    logic signed [YW-1:0] z_s, y_sum;
    logic                 vld_p1_q, vld_p2_q, vld_p3_q;

    // Stage 1: signed x unsigned product (M0 zero-extended to stay positive)
    assign acc_s  = signed'(acc_i);
    assign m0_s   = signed'({1'b0, m0_i});
    assign p_p1_d = PW'(acc_s) * PW'(m0_s);

    // Stage 2: rounding shift
    assign r_p2_d = round_shift(p_p1_q, shift_i);

    // Stage 3: zero point, ReLU floor at z_C, saturate
    always_comb begin
        z_s   = YW'(signed'(z_i));
        y_sum = YW'(r_p2_q) + z_s;
        if (relu_i && (y_sum < z_s)) y_sum = z_s;
        y_p3_d = sat_q(y_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else if (flush_i) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_i;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
        end
    end

    always_ff @(posedge clk) begin
        p_p1_q <= p_p1_d;
        r_p2_q <= r_p2_d;
        y_p3_q <= y_p3_d;
    end

    assign vld_o = vld_p3_q;
    assign y_o   = y_p3_q;
endmodule

// File: rtl/requant_packer.sv
// Collects L requantised elements into a packed output vector. Elements are
// accepted one per cycle, pass through requant_pipe, and land in consecutive
// slots; the full vector is held until the consumer acknowledges it.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   acc_in, acc_vld    : signed accumulator element and its valid
//   in_rdy             : element can be accepted this cycle
//   M0, shift, z_C     : requant multiplier, shift, signed zero point
//   relu_en            : clamp results below z_C up to z_C
//   clr                : synchronous abort of the current vector
//   out_vec, out_vld   : packed vector (slot i at [Q*i +: Q]) and its valid
//   out_ack            : consumer has taken out_vec
module requant_packer #(
    parameter int L  = 176,
    parameter int Q  = npu_quant_pkg::Q,
    parameter int DQ = npu_quant_pkg::DQ,
    parameter int MW = npu_quant_pkg::MW,
    parameter int SW = npu_quant_pkg::SW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [DQ-1:0]  acc_in,
    input  logic           acc_vld,
    output logic           in_rdy,
    input  logic [MW-1:0]  M0,
    input  logic [SW-1:0]  shift,
    input  logic [Q-1:0]   z_C,
    input  logic           relu_en,
    input  logic           clr,
    output logic [L*Q-1:0] out_vec,
    output logic           out_vld,
    input  logic           out_ack
);
    import npu_quant_pkg::*;

    localparam int CW = $clog2(L + 1);

    fill_state_e    state_q;
    logic [CW-1:0]  acc_cnt_q;
    logic [CW-1:0]  wr_cnt_q;
    logic [L*Q-1:0] out_vec_q;
    logic           xfer;
    logic           wr_vld;
    logic [Q-1:0]   wr_data;

    // Accepted count caps intake at L even while the pipe is still draining.
    assign in_rdy = (state_q == FILL) && (acc_cnt_q < CW'(L));
    assign xfer   = acc_vld && in_rdy;

    requant_pipe #(.Q(Q), .DQ(DQ), .MW(MW), .SW(SW)) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (clr),
        .vld_i   (xfer),
        .acc_i   (acc_in),
        .m0_i    (M0),
        .shift_i (shift),
        .z_i     (z_C),
        .relu_i  (relu_en),
        .vld_o   (wr_vld),
        .y_o     (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            out_vec_q <= '0;
        end else if (clr) begin
            // Vector contents survive an abort; only the bookkeeping restarts.
            state_q   <= FILL;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            if (xfer) acc_cnt_q <= acc_cnt_q + CW'(1);
            case (state_q)
                FILL: begin
                    if (wr_vld) begin
                        out_vec_q[int'(wr_cnt_q) * Q +: Q] <= wr_data;
                        if (wr_cnt_q == CW'(L - 1)) state_q <= FULL;
                        else                        wr_cnt_q <= wr_cnt_q + CW'(1);
                    end
                end
                FULL: begin
                    if (out_ack) begin
                        state_q   <= FILL;
                        acc_cnt_q <= '0;
                        wr_cnt_q  <= '0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign out_vec = out_vec_q;
    assign out_vld = (state_q == FULL);
endmodule

// File: tb/tb_requant_packer.sv
module tb_requant_packer;
    localparam int L  = 176;
    localparam int Q  = 8;
    localparam int DQ = 18;
    localparam int MW = 16;
    localparam int SW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [DQ-1:0]  acc_in;
    logic           acc_vld;
    logic           in_rdy;
    logic [MW-1:0]  M0;
    logic [SW-1:0]  shift;
    logic [Q-1:0]   z_C;
    logic           relu_en;
    logic           clr;
    logic [L*Q-1:0] out_vec;
    logic           out_vld;
    logic           out_ack;

    requant_packer #(.L(L), .Q(Q), .DQ(DQ), .MW(MW), .SW(SW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_in  (acc_in),
        .acc_vld (acc_vld),
        .in_rdy  (in_rdy),
        .M0      (M0),
        .shift   (shift),
        .z_C     (z_C),
        .relu_en (relu_en),
        .clr     (clr),
        .out_vec (out_vec),
        .out_vld (out_vld),
        .out_ack (out_ack)
    );

    always #5 clk = ~clk;

    int             total_cnt = 0;
    int             pass_cnt  = 0;
    int             acc_a [L];
    logic [L*Q-1:0] exp_v;
    logic [L*Q-1:0] cur_exp;
    logic [L*Q-1:0] exp_q [$];
    int             p_m0, p_sh, p_z;
    bit             p_relu;

    task automatic chk(input string nm, input longint act, input longint req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    // Reference: lossless product, round-half-up shift, zero point, ReLU, saturate.
    function automatic logic [Q-1:0] model(input int acc, input int m0, input int sh,
                                           input int z, input bit relu);
        longint p, r, y;
        p = longint'(acc) * longint'(m0);
        if (sh == 0) r = p;
        else         r = (p + (longint'(1) << (sh - 1))) >>> sh;
        y = r + z;
        if (relu && y < z) y = z;
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y[Q-1:0];
    endfunction

    task automatic set_params(input int m0, input int sh, input int z, input bit relu);
        p_m0 = m0; p_sh = sh; p_z = z; p_relu = relu;
        M0 = MW'(m0); shift = SW'(sh); z_C = Q'(z); relu_en = relu;
    endtask

    task automatic build_exp();
        for (int k = 0; k < L; k++) exp_v[k*Q +: Q] = model(acc_a[k], p_m0, p_sh, p_z, p_relu);
    endtask

    task automatic push_exp();
        exp_q.push_back(exp_v);
        cur_exp = exp_v;
    endtask

    // Called at a negedge; returns at the negedge after the last transfer edge.
    task automatic feed(input int from, input int to, input bit gaps);
        for (int i = from; i <= to; i++) begin
            int w;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin acc_vld = 1'b0; @(negedge clk); end
            end
            w = 0;
            while (!in_rdy && w < 20) begin acc_vld = 1'b0; @(negedge clk); w++; end
            if (!in_rdy) chk($sformatf("in_rdy_timeout_elem%0d", i), 0, 1);
            acc_vld = 1'b1;
            acc_in  = DQ'(acc_a[i]);
            @(negedge clk);
        end
        acc_vld = 1'b0;
    endtask

    task automatic wait_ack(input int hold, input bit vld_on_ack);
        int w;
        w = 0;
        while (!out_vld && w < 40) begin @(negedge clk); w++; end
        chk("out_vld_arrives", out_vld, 1);
        repeat (hold) @(negedge clk);
        chk("out_vld_held", out_vld, 1);
        chk("out_vec_held", int'(out_vec == cur_exp), 1);
        out_ack = 1'b1;
        if (vld_on_ack) begin acc_vld = 1'b1; acc_in = DQ'(77); end
        @(negedge clk);
        out_ack = 1'b0;
        acc_vld = 1'b0;
        chk("out_vld_after_ack", out_vld, 0);
        chk("in_rdy_after_ack", in_rdy, 1);
    endtask

    // Monitor: each rising out_vld must match the oldest expected vector.
    initial begin
        logic prev;
        int   vnum;
        logic [L*Q-1:0] v;
        prev = 1'b0;
        vnum = 0;
        forever begin
            @(negedge clk);
            if (out_vld && !prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_vld", 1, 0);
                end else begin
                    v = exp_q.pop_front();
                    for (int k = 0; k < L; k++)
                        chk($sformatf("vec%0d_slot%0d", vnum, k),
                            longint'($signed(out_vec[k*Q +: Q])), longint'($signed(v[k*Q +: Q])));
                end
                vnum++;
            end
            prev = out_vld;
        end
    end

    initial begin
        rst_n = 1'b0; acc_in = '0; acc_vld = 1'b0; clr = 1'b0; out_ack = 1'b0;
        set_params(1, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_rdy", in_rdy, 1);
        chk("reset_out_vld", out_vld, 0);
        chk("reset_out_vec_nonzero", int'(out_vec != '0), 0);

        // Vector 1: 100*5=500, (500+2)>>>2=125, 125-10=115 in slot 0
        set_params(5, 2, -10, 0);
        for (int k = 0; k < L; k++) acc_a[k] = (k * 37) % 400 - 200;
        acc_a[0] = 100;
        build_exp();
        exp_v[0 +: Q] = 8'd115;
        push_exp();
        feed(0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("slot0_before_3rd_edge", longint'($signed(out_vec[0 +: Q])), 0);
        @(negedge clk);
        chk("slot0_at_3rd_edge", longint'($signed(out_vec[0 +: Q])), 115);
        chk("slot1_untouched", longint'($signed(out_vec[Q +: Q])), 0);
        feed(1, L - 1, 1);
        wait_ack(2, 0);

        // Vector 2: -300*3=-900 -> -112; 1000*3 -> 127; -1000*3 -> -128
        set_params(3, 3, 0, 0);
        for (int k = 0; k < L; k++) acc_a[k] = k * 13 - 1000;
        acc_a[0] = -300; acc_a[1] = 1000; acc_a[2] = -1000;
        build_exp();
        exp_v[0 +: Q] = 8'h90;
        exp_v[Q +: Q] = 8'h7F;
        exp_v[2*Q +: Q] = 8'h80;
        push_exp();
        feed(0, L - 1, 1);
        wait_ack(1, 0);

        // Vector 3: acc=k back to back with identity requant -> sat(k)
        set_params(1, 0, 0, 0);
        for (int k = 0; k < L; k++) begin
            acc_a[k] = k;
            exp_v[k*Q +: Q] = (k > 127) ? 8'd127 : Q'(k);
        end
        push_exp();
        feed(0, L - 1, 0);
        chk("in_rdy_low_after_last", in_rdy, 0);
        @(negedge clk);
        @(negedge clk);
        chk("out_vld_low_at_2nd_edge", out_vld, 0);
        @(negedge clk);
        chk("out_vld_high_after_3rd_edge", out_vld, 1);
        set_params(1, 0, 5, 1);
        wait_ack(10, 1);

        // Vector 4: ReLU with z_C=5: -40 -> 5, 1000 -> 127
        for (int k = 0; k < L; k++) acc_a[k] = k - 100;
        acc_a[0] = -40; acc_a[1] = 1000;
        build_exp();
        exp_v[0 +: Q] = 8'd5;
        exp_v[Q +: Q] = 8'd127;
        push_exp();
        feed(0, L - 1, 1);
        wait_ack(1, 0);

        // Abort after 50 elements, then a fresh full vector
        set_params(2, 1, 3, 0);
        for (int k = 0; k < L; k++) acc_a[k] = k * 3 - 250;
        feed(0, 49, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_out_vld", out_vld, 0);
        chk("clr_in_rdy", in_rdy, 1);
        build_exp();
        push_exp();
        feed(0, L - 1, 1);
        wait_ack(1, 0);

        // Asynchronous reset mid-vector
        set_params(1, 0, 0, 0);
        for (int k = 0; k < L; k++) acc_a[k] = k;
        feed(0, 29, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_vld", out_vld, 0);
        chk("async_rst_out_vec_nonzero", int'(out_vec != '0), 0);
        chk("async_rst_in_rdy", in_rdy, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_rdy_after_release", in_rdy, 1);

        // Clean vector after reset
        set_params(1, 0, -20, 0);
        for (int k = 0; k < L; k++) acc_a[k] = k * 2 - 150;
        build_exp();
        push_exp();
        feed(0, L - 1, 1);
        wait_ack(1, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/requant_packer.md
REQUANT_PACKER -- requirements
Module: requant_packer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): L, 176, output vector length in elements; Q, 8, output quant width; DQ, 18, signed accumulator input width; MW, 16, unsigned scale multiplier width; SW, 5, right-shift amount width.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 acc_in  input  DQ  signed dot-product accumulator result, one element per transfer.
REQ-005 acc_vld  input  1  acc_in valid; a transfer occurs when acc_vld && in_rdy are high at a clock edge.
REQ-006 in_rdy  output  1  block can accept an element this cycle.
REQ-007 M0  input  MW  unsigned requant multiplier, static while a vector is being filled.
REQ-008 shift  input  SW  arithmetic right-shift amount, static while a vector is being filled.
REQ-009 z_C  input  Q  signed output zero point, static while a vector is being filled.
REQ-010 relu_en  input  1  clamp outputs below z_C up to z_C.
REQ-011 clr  input  1  synchronous abort of the current vector.
REQ-012 out_vec  output  L*Q  packed output vector; element i at bits [Q*i +: Q], same layout as vector operand inputs.
REQ-013 out_vld  output  1  out_vec holds L complete elements.
REQ-014 out_ack  input  1  consumer has taken out_vec; sampled only while out_vld is high.

Function
REQ-015 FSM states SHALL be FILL and FULL; in_rdy = (state==FILL) && (accepted count < L); out_vld = (state==FULL).
REQ-016 Accepted elements SHALL flow through a 3-stage pipeline: S1 p = acc_in * M0 (signed, DQ+MW+1 bits, lossless); S2 r = shift==0 ? p : (p + 2^(shift-1)) >>> shift; S3 y = r + z_C, then y = max(y, z_C) if relu_en, then saturate to [-2^(Q-1), 2^(Q-1)-1].
REQ-017 The k-th element accepted (k = 0..L-1) since the last FILL entry SHALL be written to out_vec slot k at the 3rd clock edge after its transfer edge; other slots SHALL be unchanged.
REQ-018 The write of slot L-1 SHALL move the FSM to FULL on the same edge; out_vld is high the following cycle.
REQ-019 In FULL, out_vec and out_vld SHALL hold until out_ack; on the out_ack edge the FSM SHALL return to FILL, clear accepted and write counters, and in_rdy rises the next cycle.
REQ-020 acc_vld while in_rdy is low SHALL be ignored, including in the same cycle as out_ack.
REQ-021 Transfers may occur on back-to-back cycles; full throughput is one element per cycle.
REQ-022 Gaps in acc_vld SHALL insert pipeline bubbles without corrupting slot ordering.
REQ-023 clr SHALL take priority over all else: it invalidates all pipeline stages, zeroes counters, and enters FILL; out_vec contents are retained but out_vld drops the next cycle.
REQ-024 out_ack while out_vld is low SHALL have no effect.

Reset
REQ-025 On rst_n low, asynchronously: state=FILL, counters=0, pipeline valids=0, out_vec=0, out_vld=0; in_rdy SHALL be 1 in the first cycle after reset release.
REQ-026 Reset asserted mid-vector SHALL discard all partial results; no out_vld pulse is produced for the aborted vector.

Structure
REQ-027 Constants Q, DQ, MW, SW and the FSM state typedef SHALL live in shared package npu_quant_pkg, reused by the vector-multiply units.
REQ-028 The S1-S3 arithmetic with its valid bits SHALL be sub-module requant_pipe; requant_packer holds FSM, counters and out_vec.

Verification
REQ-029 acc=100, M0=5, shift=2, z_C=-10, relu_en=0 -> element value 115 in slot 0, 3 edges after transfer.
REQ-030 acc=-300, M0=3, shift=3, z_C=0 -> -112; acc=1000, M0=1, shift=0 -> saturates to 127; acc=-1000 -> saturates to -128.
REQ-031 relu_en=1, z_C=5, acc=-40, M0=1, shift=0 -> 5.
REQ-032 L=176 back-to-back transfers with acc=k -> out_vld 4 cycles after the first transfer edge of... precisely: cycle after the 3rd edge following transfer 175; slot k holds sat(k); in_rdy low for the cycle after transfer 175 onward; hold 10 cycles, then out_ack -> FILL and in_rdy high the next cycle.
REQ-033 Random acc_vld gaps plus clr after 50 elements -> no out_vld; next 176 elements fill slots 0..175 in order.
REQ-034 rst_n pulsed low mid-vector -> all outputs reset immediately, in_rdy=1 after release.
